// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants for the debounce scanner.
//   ST_IDLE / ST_SCAN     - scanner FSM encodings
//   TICK_DIV_1MS_16MHZ    - default prescaler divide (1 ms at 16 MHz)
//   clog2()               - ceil(log2(v)), used for index/counter widths
package debounce_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  localparam int unsigned TICK_DIV_1MS_16MHZ = 16000;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/debounce_scan_tick_gen.sv
// tick_gen: free-running prescaler, counts 0..TICK_DIV-1 and wraps.
//   clk  - system clock
//   rst  - synchronous active-high reset (count -> 0)
//   tick - high for one clock while the count sits at TICK_DIV-1
module tick_gen
  import debounce_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_1MS_16MHZ
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned W = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap;

  assign wrap = (cnt_q == W'(TICK_DIV - 1));
  assign tick = wrap;

  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/debounce_scan.sv
// debounce_scan: time-multiplexed debouncer for N inputs. One prescaler tick
// starts a scan that visits one input per clock (slot i = i clocks after the
// scan starts); each slot compares the synchronized input with its debounced
// level and updates that input's stable counter.
//   clk  - system clock          rst  - synchronous active-high reset
//   in   - raw async inputs [N]  db   - debounced levels [N]
//   rise - 0->1 pulse [N]        fall - 1->0 pulse [N]
//   busy - scan in progress      rpt  - auto-repeat pulse [N]
// Optional macro DEBOUNCE_SCAN_REPEAT_EN adds per-input hold counters driving
// rpt; without it rpt is tied to 0.
module debounce_scan
  import debounce_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned TICK_DIV  = TICK_DIV_1MS_16MHZ,
  parameter int unsigned STABLE    = 10,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned RPT_DELAY = 500,
  parameter int unsigned RPT_RATE  = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  output logic [N-1:0] db,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         busy,
  output logic [N-1:0] rpt
);

  localparam int unsigned IDX_W = (N > 1) ? clog2(N) : 1;

  // A tick arriving mid-scan would corrupt idx; the counter must hold STABLE-1.
  if (TICK_DIV < N + 2) begin : g_bad_tick_div
    $error("debounce_scan: TICK_DIV must be >= N+2");
  end
  if ((64'd1 << CNT_W) <= 64'(STABLE)) begin : g_bad_cnt_w
    $error("debounce_scan: 2**CNT_W must exceed STABLE");
  end
  if (STABLE < 1 || RPT_RATE < 1 || RPT_RATE > RPT_DELAY) begin : g_bad_rpt
    $error("debounce_scan: need STABLE >= 1 and 1 <= RPT_RATE <= RPT_DELAY");
  end

  logic             tick;
  logic [N-1:0]     sync_q, s_q;
  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [N-1:0]     db_q, db_d, rise_q, rise_d, fall_q, fall_d;
  logic [N-1:0]     slot_v, flip_v;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: if (tick) begin
        state_d = ST_SCAN;
        idx_d   = '0;
      end
      ST_SCAN: if (idx_q == IDX_W'(N - 1)) begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    slot_v = '0;
    flip_v = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      slot_v[i] = (state_q == ST_SCAN) && (idx_q == IDX_W'(i));
      if (slot_v[i]) begin
        if (s_q[i] == db_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_W'(STABLE - 1)) begin
          flip_v[i] = 1'b1;
          db_d[i]   = ~db_q[i];
          cnt_d[i]  = '0;
          rise_d[i] = ~db_q[i];
          fall_d[i] = db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      s_q     <= '0;
      state_q <= ST_IDLE;
      idx_q   <= '0;
      db_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      sync_q  <= in;
      s_q     <= sync_q;
      state_q <= state_d;
      idx_q   <= idx_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef DEBOUNCE_SCAN_REPEAT_EN
  localparam int unsigned HC_W = clog2(RPT_DELAY + 1);

  logic [HC_W-1:0] hc_q [N];
  logic [HC_W-1:0] hc_d [N];
  logic [N-1:0]    rpt_q, rpt_d;

  // Reloading to RPT_DELAY-RPT_RATE makes later repeats RPT_RATE ticks apart.
  always_comb begin
    rpt_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      hc_d[i] = hc_q[i];
      if (slot_v[i]) begin
        if (!db_q[i] || flip_v[i]) begin
          hc_d[i] = '0;
        end else if (hc_q[i] == HC_W'(RPT_DELAY - 1)) begin
          rpt_d[i] = 1'b1;
          hc_d[i]  = HC_W'(RPT_DELAY - RPT_RATE);
        end else begin
          hc_d[i] = hc_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_q <= '0;
      for (int unsigned i = 0; i < N; i++) hc_q[i] <= '0;
    end else begin
      rpt_q <= rpt_d;
      for (int unsigned i = 0; i < N; i++) hc_q[i] <= hc_d[i];
    end
  end

  assign rpt = rpt_q;
`else
  assign rpt = '0;
`endif

  assign db   = db_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == ST_SCAN);

endmodule

// File: tb/tb_debounce_scan.sv
// tb_debounce_scan: directed bench for debounce_scan with N=4, TICK_DIV=16,
// STABLE=3, RPT_DELAY=4, RPT_RATE=2. cyc counts clocks since reset release,
// so tick cycles are 16n-1, slot i of scan n is cycle 16n+i and its result is
// visible at 16n+i+1. An input driven in cycle x is seen by slots at >= x+2.
module tb_debounce_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_r = '0;
  logic [3:0] db, rise, fall, rpt;
  logic       busy;

  debounce_scan #(
    .N(4), .TICK_DIV(16), .STABLE(3), .CNT_W(2), .RPT_DELAY(4), .RPT_RATE(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .in   (in_r),
    .db   (db),
    .rise (rise),
    .fall (fall),
    .busy (busy),
    .rpt  (rpt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Pulse log, cleared while rst is high.
  int rise_cnt [4];
  int fall_cnt [4];
  int rpt_cnt  [4];
  int rise_cyc [4];
  int fall_cyc [4];
  int both_cnt = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        rise_cnt[i] = 0; fall_cnt[i] = 0; rpt_cnt[i] = 0;
        rise_cyc[i] = -1; fall_cyc[i] = -1;
      end else begin
        if (rise[i]) begin rise_cnt[i] = rise_cnt[i] + 1; rise_cyc[i] = cyc; end
        if (fall[i]) begin fall_cnt[i] = fall_cnt[i] + 1; fall_cyc[i] = cyc; end
        if (rpt[i])  rpt_cnt[i] = rpt_cnt[i] + 1;
        if (rise[i] && fall[i]) both_cnt = both_cnt + 1;
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to 1 time unit after the edge that starts cycle c.
  task automatic goto_cyc(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 5000) begin
      @(posedge clk); #1;
      guard = guard + 1;
    end
    check("cycle_reached", cyc, c);
  endtask

  task automatic do_reset(input logic [3:0] after);
    rst  = 1'b1;
    in_r = 4'hF;
    repeat (5) @(posedge clk);
    #1;
    rst  = 1'b0;
    in_r = after;
  endtask

  initial begin
    // 1: reset state and first scan window
    rst = 1'b1; in_r = 4'hF;
    repeat (5) @(posedge clk);
    #1;
    check("rst_db",   int'(db),   0);
    check("rst_rise", int'(rise), 0);
    check("rst_fall", int'(fall), 0);
    check("rst_rpt",  int'(rpt),  0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0; in_r = 4'h0;
    goto_cyc(15); check("busy_before", int'(busy), 0);
    goto_cyc(16); check("busy_first",  int'(busy), 1);
    goto_cyc(19); check("busy_last",   int'(busy), 1);
    goto_cyc(20); check("busy_after",  int'(busy), 0);

    // 2: clean press / release of in[2]
    in_r = 4'b0100;
    goto_cyc(66); check("press_db_pre",  int'(db),   4'b0000);
    check("press_rise_pre", int'(rise), 0);
    goto_cyc(67); check("press_rise",    int'(rise), 4'b0100);
    check("press_db",       int'(db),   4'b0100);
    goto_cyc(68); check("press_rise_1clk", int'(rise), 0);
    goto_cyc(70); in_r = 4'b0000;
    goto_cyc(114); check("rel_db_pre", int'(db), 4'b0100);
    goto_cyc(115); check("rel_fall",   int'(fall), 4'b0100);
    check("rel_db",          int'(db),   0);
    goto_cyc(130);
    check("press_rise_cnt",  rise_cnt[2], 1);
    check("rel_fall_cnt",    fall_cnt[2], 1);
    check("press_other_rise", rise_cnt[0] + rise_cnt[1] + rise_cnt[3], 0);
    check("press_other_fall", fall_cnt[0] + fall_cnt[1] + fall_cnt[3], 0);
`ifndef DEBOUNCE_SCAN_REPEAT_EN
    check("rpt_tied_off", rpt_cnt[0] + rpt_cnt[1] + rpt_cnt[2] + rpt_cnt[3], 0);
`endif

    // 3: in[1] bounces with a 10-clock half period, then holds high at 256
    do_reset(4'b0000);
    for (int k = 0; k < 12; k++) begin
      goto_cyc(136 + 10 * k);
      in_r[1] = (k % 2 == 0);
    end
    goto_cyc(256); in_r[1] = 1'b1;
    goto_cyc(305);
    check("bounce_db_held", int'(db), 0);
    check("bounce_no_rise", rise_cnt[1], 0);
    goto_cyc(306);
    check("bounce_rise", int'(rise), 4'b0010);
    check("bounce_db",   int'(db),   4'b0010);
    goto_cyc(320);
    check("bounce_rise_cnt", rise_cnt[1], 1);

    // 4: in[0] and in[3] rise together
    do_reset(4'b0000);
    goto_cyc(20); in_r = 4'b1001;
    goto_cyc(65); check("simul_rise0", int'(rise), 4'b0001);
    goto_cyc(66); check("simul_gap",   int'(rise), 0);
    goto_cyc(68); check("simul_rise3", int'(rise), 4'b1000);
    check("simul_db",   int'(db), 4'b1001);
    goto_cyc(80);
    check("simul_spacing", rise_cyc[3] - rise_cyc[0], 3);

    // 5: reset lands on slot 1 of the scan that would flip db[1]
    do_reset(4'b0010);
    goto_cyc(49);
    check("mid_db_pre", int'(db), 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_db",   int'(db),   0);
    check("mid_rst_rise", int'(rise), 0);
    rst = 1'b0;
    goto_cyc(49);
    check("mid_no_rise_early", rise_cnt[1], 0);
    goto_cyc(50);
    check("mid_rise_recur", int'(rise), 4'b0010);
    check("mid_db",         int'(db),   4'b0010);

`ifdef DEBOUNCE_SCAN_REPEAT_EN
    // 6: hold in[0]: rise at 49, repeats at 113, 145, 177, 209; fall at 225
    do_reset(4'b0001);
    goto_cyc(49);  check("rep_rise",   int'(rise), 4'b0001);
    goto_cyc(112); check("rep_pre",    int'(rpt),  0);
    goto_cyc(113); check("rep_first",  int'(rpt),  4'b0001);
    goto_cyc(145); check("rep_second", int'(rpt),  4'b0001);
    goto_cyc(177); check("rep_third",  int'(rpt),  4'b0001);
    goto_cyc(180); in_r = 4'b0000;
    goto_cyc(209); check("rep_fourth", int'(rpt),  4'b0001);
    goto_cyc(225); check("rep_fall",   int'(fall), 4'b0001);
    goto_cyc(300);
    check("rep_count",      rpt_cnt[0],  4);
    check("rep_fall_count", fall_cnt[0], 1);
`endif

    check("rise_fall_overlap", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
